// File: rtl/spi_slave_rx_fifo.sv
// spi_slave_rx_fifo: oversampled SPI slave receiver feeding a show-ahead word FIFO
//   clk, reset          system clock, synchronous active-high reset
//   sck, sdi, cs_n      asynchronous SPI pins from the master
//   rd_en               pop the head word when rd_valid is high
//   rd_data, rd_valid   head word and FIFO-not-empty flag
//   fifo_count          number of words held
//   frame_err           one-cycle pulse when cs_n rises on a partial word
//   overflow            sticky flag set when a word was dropped because the FIFO was full
module spi_slave_rx_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sck,
    input  logic                               sdi,
    input  logic                               cs_n,
    input  logic                               rd_en,
    output logic [WIDTH-1:0]                   rd_data,
    output logic                               rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               frame_err,
    output logic                               overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_next;
    logic [2:0]       sck_s;
    logic [1:0]       sdi_s, cs_s;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg, shift_next;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             sample, shift_en, last, abort, full, pop, wr;

    // sck_s[2] is the extra stage used only for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s <= (CPOL != 0) ? 3'b111 : 3'b000;
            cs_s  <= 2'b11;
            sdi_s <= 2'b00;
        end else begin
            sck_s <= {sck_s[1:0], sck};
            cs_s  <= {cs_s[0], cs_n};
            sdi_s <= {sdi_s[0], sdi};
        end
    end

    // rising sck samples when CPOL==CPHA, falling sck otherwise
    assign sample = (CPOL == CPHA) ? (sck_s[1] & ~sck_s[2]) : (~sck_s[1] & sck_s[2]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = cs_s[1] ? IDLE : ACTIVE;
        shift_en   = (state == ACTIVE) && !cs_s[1] && sample;
        last       = shift_en && (bit_cnt == BW'(WIDTH-1));
        abort      = (state == ACTIVE) && cs_s[1] && (bit_cnt != '0);
        shift_next = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], sdi_s[1]} : {sdi_s[1], shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (shift_en) begin
                shreg   <= shift_next;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            end else if (state != ACTIVE || cs_s[1]) begin
                bit_cnt <= '0;
            end
        end
    end

    // a simultaneous pop frees a slot, so a push into a full FIFO still succeeds
    assign rd_valid = fifo_count != '0;
    assign full     = fifo_count == CW'(FIFO_DEPTH);
    assign pop      = rd_en && rd_valid;
    assign wr       = last && (!full || pop);
    assign rd_data  = rd_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= shift_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + CW'(wr) - CW'(pop);
            overflow   <= overflow | (last && full && !pop);
        end
    end
endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// tb_spi_slave_rx_fifo: directed bench for spi_slave_rx_fifo in mode 0 MSB-first and mode 3 LSB-first
module tb_spi_slave_rx_fifo;
    logic        clk = 1'b0, reset = 1'b1, sck0 = 1'b0, sck1 = 1'b1, sdi = 1'b0, cs_n = 1'b1, rd_en = 1'b0;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, frame_err0, frame_err1, overflow0, overflow1;
    logic [2:0]  fifo_count0, fifo_count1;
    int          checks = 0, failures = 0, fe_cnt = 0, fe_base;
    logic [31:0] words [5] = '{32'h11111111, 32'h2222C0DE, 32'h33334444, 32'h5A5A0F0F, 32'h9876ABCD};

    always #5 clk = ~clk;

    spi_slave_rx_fifo #(.WIDTH(32), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .reset(reset), .sck(sck0), .sdi(sdi), .cs_n(cs_n), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(fifo_count0),
        .frame_err(frame_err0), .overflow(overflow0));

    spi_slave_rx_fifo #(.WIDTH(32), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .reset(reset), .sck(sck1), .sdi(sdi), .cs_n(cs_n), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(fifo_count1),
        .frame_err(frame_err1), .overflow(overflow1));

    always @(negedge clk) if (frame_err0) fe_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // sck0 (mode 0) and sck1 (mode 3) both sample on the rising edge, so one bit stream feeds both
    task automatic send_word(input logic [31:0] w, input int nbits, input bit pop_last);
        for (int i = 0; i < nbits; i++) begin
            sdi = w[31-i]; sck0 = 1'b0; sck1 = 1'b0;
            repeat (4) @(negedge clk);
            sck0 = 1'b1; sck1 = 1'b1;
            if (pop_last && i == nbits-1) begin
                repeat (2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                @(negedge clk);
            end else repeat (4) @(negedge clk);
        end
        sck0 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data0, 32'h0);
        check("rst_rd_valid", 32'(rd_valid0), 32'd0);
        check("rst_count", 32'(fifo_count0), 32'd0);
        check("rst_frame_err", 32'(frame_err0), 32'd0);
        check("rst_overflow", 32'(overflow0), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        cs_low(); send_word(32'hDEADBEEF, 32, 0); cs_high();
        check("m0_valid", 32'(rd_valid0), 32'd1);
        check("m0_data", rd_data0, 32'hDEADBEEF);
        check("m0_count", 32'(fifo_count0), 32'd1);
        check("m3_lsb_data", rd_data1, 32'hF77DB57B);
        pop();
        check("m0_pop_count", 32'(fifo_count0), 32'd0);

        cs_low(); send_word(32'h00000001, 32, 0); cs_high();
        check("m3_lsb_one", rd_data1, 32'h80000000);
        check("m0_one", rd_data0, 32'h00000001);
        pop();

        cs_low();
        for (int i = 0; i < 5; i++) send_word(words[i], 32, 0);
        cs_high();
        check("ovf_count", 32'(fifo_count0), 32'd4);
        check("ovf_flag", 32'(overflow0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_word%0d", i), rd_data0, words[i]);
            pop();
        end
        check("ovf_drain", 32'(rd_valid0), 32'd0);
        pop();
        check("empty_pop_count", 32'(fifo_count0), 32'd0);

        fe_base = fe_cnt;
        cs_low(); send_word(32'hFFFFFFFF, 13, 0); cs_high();
        check("ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
        check("ferr_count", 32'(fifo_count0), 32'd0);

        cs_low(); send_word(32'hA5C30F96, 32, 0); cs_high();
        check("after_ferr_data", rd_data0, 32'hA5C30F96);
        check("after_ferr_count", 32'(fifo_count0), 32'd1);
        pop();

        do_reset();
        check("rst_ovf_clear", 32'(overflow0), 32'd0);
        cs_low();
        for (int i = 0; i < 4; i++) send_word(words[i], 32, 0);
        send_word(words[4], 32, 1);
        cs_high();
        check("full_pop_count", 32'(fifo_count0), 32'd4);
        check("full_pop_ovf", 32'(overflow0), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("full_pop_word%0d", i), rd_data0, words[i]);
            pop();
        end
        for (int i = 0; i < 3; i++) pop();
        cs_low(); send_word(32'h0BADF00D, 32, 0); cs_high();
        check("wrap_data", rd_data0, 32'h0BADF00D);

        fe_base = fe_cnt;
        cs_low(); send_word(32'hCAFEF00D, 20, 0);
        reset = 1'b1; cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_count", 32'(fifo_count0), 32'd0);
        cs_low(); send_word(32'h12345678, 32, 0); cs_high();
        check("midrst_data", rd_data0, 32'h12345678);
        check("midrst_new_count", 32'(fifo_count0), 32'd1);
        check("midrst_ferr", 32'(fe_cnt - fe_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
